// File: rtl/melody_pkg.sv
// Shared definitions for the melody player: note codes, tone period table,
// FSM state type and the song ROM.
package melody_pkg;

    localparam int PERIOD_W = 20;

    typedef logic [3:0]          note_t;
    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    localparam note_t NOTE_REST = 4'd0;
    localparam note_t DO_       = 4'd1;
    localparam note_t RE_       = 4'd2;
    localparam note_t MI_       = 4'd3;
    localparam note_t FA_       = 4'd4;
    localparam note_t SO_       = 4'd5;
    localparam note_t LA_       = 4'd6;
    localparam note_t SI_       = 4'd7;
    localparam note_t DO        = 4'd8;
    localparam note_t RE        = 4'd9;
    localparam note_t MI        = 4'd10;
    localparam note_t FA        = 4'd11;
    localparam note_t SO        = 4'd12;
    localparam note_t LA        = 4'd13;
    localparam note_t SI        = 4'd14;
    localparam note_t NOTE_END  = 4'd15;

    function automatic int unsigned note_freq(input note_t code);
        case (code)
            DO_:     return 262;
            RE_:     return 294;
            MI_:     return 330;
            FA_:     return 349;
            SO_:     return 392;
            LA_:     return 440;
            SI_:     return 494;
            DO:      return 523;
            RE:      return 587;
            MI:      return 659;
            FA:      return 698;
            SO:      return 784;
            LA:      return 880;
            SI:      return 988;
            default: return 0;
        endcase
    endfunction

    // Rest and END have no frequency and get period 0; they never sound.
    function automatic int unsigned note_period(input int unsigned clk_freq, input note_t code);
        int unsigned f;
        f = note_freq(code);
        return (f == 0) ? 0 : clk_freq / f;
    endfunction

    function automatic logic [15:0][PERIOD_W-1:0] period_table(input int unsigned clk_freq);
        logic [15:0][PERIOD_W-1:0] t;
        for (int k = 0; k < 16; k++) begin
            t[k] = PERIOD_W'(note_period(clk_freq, note_t'(k)));
        end
        return t;
    endfunction

    // Indexed by {song, slot}; anything not listed plays as END.
    function automatic note_t song_rom(input logic [3:0] song, input logic [7:0] slot);
        case ({song, slot})
            12'h000: return MI;
            12'h001: return RE;
            12'h002: return DO;
            12'h003: return NOTE_REST;
            12'h004: return SO;
            12'h005: return LA;
            12'h006: return SI;
            12'h007: return DO_;
            12'h100: return DO;
            12'h101: return MI;
            12'h102: return SO;
            12'h103: return NOTE_REST;
            12'h104: return MI_;
            default: return NOTE_END;
        endcase
    endfunction

endpackage

// File: rtl/melody_tone_gen.sv
// Tone counter and duty compare; produces the registered active-low buzzer drive.
module tone_gen
    import melody_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  period_t period_i,
    input  logic [2:0] volume_i,
    input  logic    enable_i,
    input  logic    slot_clear_i,
    output logic    pwm_n_o
);

    period_t tone_cnt_q, tone_cnt_d;
    period_t thr;
    logic    pwm_n_q, pwm_n_d;

    // Louder volume widens the low pulse; 7 gives half the period.
    assign thr = period_i >> (4'd8 - {1'b0, volume_i});

    always_comb begin
        tone_cnt_d = tone_cnt_q;
        if (slot_clear_i) begin
            tone_cnt_d = '0;
        end else if (enable_i) begin
            tone_cnt_d = (tone_cnt_q >= period_i - 1'b1) ? '0 : tone_cnt_q + 1'b1;
        end
        pwm_n_d = !(enable_i && (volume_i != 3'd0) && (tone_cnt_q < thr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt_q <= '0;
            pwm_n_q    <= 1'b1;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            pwm_n_q    <= pwm_n_d;
        end
    end

    assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/melody_player.sv
// Song sequencer: walks the ROM slot by slot, handles start/stop/loop and
// drives the tone generator.
module melody_player
    import melody_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int NOTE_TICKS = 15_000_000,
    parameter int SONG_LEN   = 64,
    parameter int NUM_SONGS  = 4,
    localparam int SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [SEL_W-1:0] song_sel,
    input  logic [2:0]       volume,
    output logic             busy,
    output logic             done,
    output logic [7:0]       note_idx,
    output logic             pwm
);

    localparam int SLOT_W = $clog2(NOTE_TICKS);
    localparam int ART    = (NOTE_TICKS >> 1) + (NOTE_TICKS >> 2);
    localparam logic [15:0][PERIOD_W-1:0] PERIOD_TAB = period_table(CLK_FREQ);

    if (note_period(CLK_FREQ, DO_) >= (1 << PERIOD_W)) begin : g_period_ovf
        $error("melody_player: tone period does not fit in 20 bits");
    end
    if (SONG_LEN < 2 || SONG_LEN > 256) begin : g_len_chk
        $error("melody_player: SONG_LEN out of range");
    end
    if (NUM_SONGS < 1 || NUM_SONGS > 16 || (NUM_SONGS & (NUM_SONGS - 1)) != 0) begin : g_songs_chk
        $error("melody_player: NUM_SONGS must be a power of two in 1..16");
    end

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [7:0]        note_idx_q, note_idx_d;
    logic              loop_q, loop_d;
    logic [SEL_W-1:0]  song_q, song_d;
    logic              done_q, done_d;
    logic              slot_wrap, end_pass;
    logic [3:0]        song_idx;
    note_t             cur_code, next_code;
    logic              is_tone, tone_en, slot_clear;

    assign song_idx  = 4'(song_q) & 4'(NUM_SONGS - 1);
    assign cur_code  = song_rom(song_idx, note_idx_q);
    assign next_code = song_rom(song_idx, note_idx_q + 8'd1);

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        note_idx_d = note_idx_q;
        loop_d     = loop_q;
        song_d     = song_q;
        done_d     = 1'b0;
        slot_wrap  = 1'b0;
        end_pass   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_PLAY;
                    loop_d     = loop;
                    song_d     = song_sel;
                    note_idx_d = '0;
                    slot_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    note_idx_d = '0;
                    slot_cnt_d = '0;
                end else if (cur_code == NOTE_END) begin
                    end_pass = 1'b1;
                end else if (slot_cnt_q == SLOT_W'(NOTE_TICKS - 1)) begin
                    // Look ahead so a pass ending on an END slot lasts whole slots.
                    slot_wrap  = 1'b1;
                    slot_cnt_d = '0;
                    if (note_idx_q == 8'(SONG_LEN - 1) || next_code == NOTE_END) begin
                        end_pass = 1'b1;
                    end else begin
                        note_idx_d = note_idx_q + 8'd1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
                if (end_pass) begin
                    done_d     = 1'b1;
                    note_idx_d = '0;
                    slot_cnt_d = '0;
                    if (!loop_q) state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            note_idx_q <= '0;
            loop_q     <= 1'b0;
            song_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            note_idx_q <= note_idx_d;
            loop_q     <= loop_d;
            song_q     <= song_d;
            done_q     <= done_d;
        end
    end

    assign is_tone    = (cur_code != NOTE_REST) && (cur_code != NOTE_END);
    assign tone_en    = (state_q == ST_PLAY) && !stop && is_tone && (slot_cnt_q < SLOT_W'(ART));
    assign slot_clear = (state_q != ST_PLAY) || stop || slot_wrap || end_pass;

    tone_gen u_tone (
        .clk          (clk),
        .rst          (rst),
        .period_i     (PERIOD_TAB[cur_code]),
        .volume_i     (volume),
        .enable_i     (tone_en),
        .slot_clear_i (slot_clear),
        .pwm_n_o      (pwm)
    );

    assign busy     = (state_q == ST_PLAY);
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule

// File: tb/tb_melody_player.sv
// Randomized bench: a time-based reference model predicts busy/done/note_idx/pwm
// after every clock edge; a monitor compares them on the falling edge.
module tb_melody_player;

    localparam int CLK = 1_000_000;
    localparam int NT  = 400;
    localparam int SL  = 8;
    localparam int ART = NT * 3 / 4;
    localparam int FREQ [15] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                 523, 587, 659, 698, 784, 880, 988};
    localparam int SONGS [2][8] = '{'{10, 9, 8, 0, 12, 13, 14, 1},
                                    '{8, 10, 12, 0, 3, 15, 15, 15}};

    typedef struct {
        bit busy;
        bit done;
        int idx;
        bit pwm;
        int cyc;
    } exp_t;

    typedef enum {M_IDLE, M_PLAY, M_DONE} mph_t;

    logic       clk, rst, start, stop, loop;
    logic [0:0] song_sel;
    logic [2:0] volume;
    logic       busy, done, pwm;
    logic [7:0] note_idx;

    exp_t q[$];
    int   n_checks = 0, n_fail = 0, n_mon = 0, done_seen = 0;
    mph_t mph = M_IDLE;
    int   mcyc = 0, ms = 0, msong = 0, mT = NT;
    bit   mloop = 0;

    melody_player #(.CLK_FREQ(CLK), .NOTE_TICKS(NT), .SONG_LEN(SL), .NUM_SONGS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .song_sel(song_sel), .volume(volume), .busy(busy), .done(done),
        .note_idx(note_idx), .pwm(pwm)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int pass_slots(int s);
        for (int i = 0; i < SL; i++) if (SONGS[s][i] == 15) return i;
        return SL;
    endfunction

    // Whether the buzzer is driven low during cycle ep of the current song.
    function automatic bit tone_low(int ep, int vol);
        int pos, slot, k, code, p;
        pos  = ep % mT;
        slot = pos / NT;
        k    = pos % NT;
        code = SONGS[msong][slot];
        if (code == 0 || code == 15 || vol == 0 || k >= ART) return 0;
        p = CLK / FREQ[code];
        return (k % p) < (p >> (8 - vol));
    endfunction

    task automatic model_step();
        exp_t ex;
        int   e;
        ex.busy = 0; ex.done = 0; ex.idx = 0; ex.pwm = 1;
        mcyc++;
        case (mph)
            M_IDLE: if (start && !stop) begin
                mph = M_PLAY; ms = mcyc; msong = int'(song_sel); mloop = loop;
                mT = pass_slots(msong) * NT;
                ex.busy = 1;
            end
            M_DONE: mph = M_IDLE;
            default: if (stop) mph = M_IDLE;
            else begin
                e = mcyc - ms;
                ex.pwm  = !tone_low(e - 1, int'(volume));
                ex.done = (e % mT == 0);
                if (!mloop && e == mT) mph = M_DONE;
                else begin
                    ex.busy = 1;
                    ex.idx  = (e % mT) / NT;
                end
            end
        endcase
        ex.cyc = mcyc;
        q.push_back(ex);
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) mph = M_IDLE;
        else model_step();
    end

    initial forever begin
        exp_t ex;
        @(negedge clk);
        if (rst) q.delete();
        else if (q.size() > 0) begin
            ex = q.pop_front();
            n_checks++; n_mon++;
            if (busy !== ex.busy || done !== ex.done || note_idx !== 8'(ex.idx) || pwm !== ex.pwm) begin
                n_fail++;
                $display("FAIL outputs@%0d: got busy=%0b done=%0b note_idx=%0d pwm=%0b, expected busy=%0b done=%0b note_idx=%0d pwm=%0b",
                         ex.cyc, busy, done, note_idx, pwm, ex.busy, ex.done, ex.idx, ex.pwm);
            end
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(int n, int vol_pct, int start_pct);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < vol_pct) volume = 3'($urandom_range(7));
            start = ($urandom_range(99) < start_pct);
            if (start) begin
                loop     = 1'($urandom_range(1));
                song_sel = 1'($urandom_range(1));
            end
            tick(1);
        end
        start = 0;
    endtask

    task automatic play(int s, bit lp, int vol);
        song_sel = 1'(s); loop = lp; volume = 3'(vol);
        start = 1;
        tick(1);
        start = 0;
    endtask

    initial begin
        int d0;
        rst = 1; start = 0; stop = 0; loop = 0; song_sel = 0; volume = 7;
        #1;
        chk("reset pwm", int'(pwm), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset note_idx", int'(note_idx), 0);
        tick(3);
        rst = 0;
        tick(2);

        // Song 0 once at full volume, with ignored start pulses mid-song
        d0 = done_seen;
        play(0, 0, 7);
        chk("busy one cycle after start", int'(busy), 1);
        tick(1);
        chk("first pwm low", int'(pwm), 0);
        run(1500, 0, 2);
        run(1800, 0, 0);
        chk("song0 done pulses", done_seen - d0, 1);
        chk("song0 idle after pass", int'(busy), 0);

        // Same song with volume wandering, including mute and mid-note changes
        play(0, 0, 3);
        run(1300, 0, 0);
        run(2000, 4, 0);

        // Looping song 1 (END at slot 5), stopped partway through the third pass
        d0 = done_seen;
        play(1, 1, 7);
        run(4498, 2, 0);
        chk("loop still busy", int'(busy), 1);
        stop = 1;
        tick(1);
        stop = 0;
        chk("busy after stop", int'(busy), 0);
        chk("pwm after stop", int'(pwm), 1);
        chk("loop done pulses", done_seen - d0, 2);
        run(10, 0, 0);

        // Start and stop together while idle
        start = 1; stop = 1;
        tick(1);
        start = 0; stop = 0;
        chk("start+stop idle busy", int'(busy), 0);
        run(5, 0, 0);
        chk("start+stop stays idle", int'(busy), 0);

        // Asynchronous reset in the middle of slot 3
        play(0, 1, 5);
        run(3 * NT + 150, 0, 0);
        #2 rst = 1;
        #1;
        chk("async rst pwm", int'(pwm), 1);
        chk("async rst busy", int'(busy), 0);
        chk("async rst note_idx", int'(note_idx), 0);
        tick(1);
        rst = 0;
        tick(1);
        play(0, 0, 7);
        chk("restart note_idx", int'(note_idx), 0);
        run(600, 2, 0);
        chk("restart slot1", int'(note_idx), 1);

        // Random sessions: starts, stops, loops, volume changes
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(3) == 0) begin
                stop = 1;
                start = 1'($urandom_range(1));
                tick(1);
                stop = 0; start = 0;
            end
            play($urandom_range(1), 1'($urandom_range(1)), $urandom_range(7));
            run($urandom_range(200, 2500), 3, 1);
            if ($urandom_range(1) == 1) begin
                stop = 1;
                tick(1);
                stop = 0;
            end
        end
        stop = 1;
        tick(1);
        stop = 0;
        run(20, 0, 0);
        chk("monitor activity", int'(n_mon > 10000), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
